// File: rtl/conv_bus_pkg.sv
// Shared types and constants for the convolution read-burst path.
package conv_bus_pkg;

    // Read-address length field width and transaction ID width.
    localparam int unsigned ARLEN_W = 8;
    localparam int unsigned ID_W    = 4;

    // ID used by the read bridge unless overridden at instantiation.
    localparam logic [ID_W-1:0] RD_ID_DEFAULT = 4'h1;

    // Bridge sequencing states.
    typedef enum logic [1:0] {
        StIdle,
        StAddr,
        StData,
        StOut
    } state_e;

endpackage

// File: rtl/conv_rd_pack.sv
// Packs read beats into a channel vector at a beat-indexed slot.
module conv_rd_pack #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned BEATS  = 64,
    parameter int unsigned IDX_W  = 6
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [IDX_W-1:0]        wr_idx,
    input  logic [DATA_W-1:0]       wr_data,
    output logic [BEATS*DATA_W-1:0] data
);

    // Store each accepted beat in its slot; untouched slots keep old contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= '0;
        end else if (wr_en) begin
            data[wr_idx*DATA_W +: DATA_W] <= wr_data;
        end
    end

endmodule

// File: rtl/conv_rd_burst_bridge.sv
// Fetches channel vectors from memory as fixed-length read bursts and
// presents each assembled vector on a valid/ready output.
module conv_rd_burst_bridge
    import conv_bus_pkg::*;
#(
    parameter int unsigned      CH_NUM    = 64,
    parameter int unsigned      PIX_W     = 32,
    parameter int unsigned      DATA_W    = 32,
    parameter int unsigned      BURST_LEN = 16,
    parameter int unsigned      ADDR_W    = 28,
    parameter logic [ID_W-1:0]  RD_ID     = RD_ID_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [ADDR_W-1:0]         req_addr,
    input  logic [15:0]               req_num,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CH_NUM*PIX_W-1:0]   out_data,
    output logic                      arvalid,
    input  logic                      arready,
    output logic [ADDR_W-1:0]         araddr,
    output logic [ARLEN_W-1:0]        arlen,
    output logic [ID_W-1:0]           arid,
    input  logic                      rvalid,
    output logic                      rready,
    input  logic [DATA_W-1:0]         rdata,
    input  logic [ID_W-1:0]           rid,
    input  logic                      rlast,
    output logic                      err
);

    localparam int unsigned BEATS  = CH_NUM * PIX_W / DATA_W;
    localparam int unsigned BURSTS = BEATS / BURST_LEN;
    localparam int unsigned STRIDE = BURST_LEN * DATA_W / 8;
    localparam int unsigned IDX_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned VB_W   = $clog2(BEATS + 1);
    localparam int unsigned BB_W   = $clog2(BURST_LEN + 1);
    localparam int unsigned BC_W   = (BURSTS > 1) ? $clog2(BURSTS) : 1;

    localparam logic [VB_W-1:0]    BEATS_V      = VB_W'(BEATS);
    localparam logic [BB_W-1:0]    BURST_LEN_V  = BB_W'(BURST_LEN);
    localparam logic [BB_W-1:0]    LAST_BEAT_V  = BB_W'(BURST_LEN - 1);
    localparam logic [BC_W-1:0]    LAST_BURST_V = BC_W'(BURSTS - 1);
    localparam logic [ARLEN_W-1:0] ARLEN_V      = ARLEN_W'(BURST_LEN - 1);
    localparam logic [ADDR_W-1:0]  STRIDE_V     = ADDR_W'(STRIDE);

    if ((CH_NUM * PIX_W) % DATA_W != 0) begin : g_bad_beats
        $error("CH_NUM*PIX_W must be a multiple of DATA_W");
    end
    if (BEATS % BURST_LEN != 0 || BURSTS == 0) begin : g_bad_bursts
        $error("BEATS must be a non-zero multiple of BURST_LEN");
    end
    if ((BURST_LEN * DATA_W) % 8 != 0) begin : g_bad_stride
        $error("burst size must be a whole number of bytes");
    end

    state_e            state_q;
    logic [ADDR_W-1:0] cur_addr;
    logic [15:0]       vec_left;
    logic [BC_W-1:0]   burst_cnt;
    logic [BB_W-1:0]   burst_beat;
    logic [VB_W-1:0]   vec_beat;

    logic              beat_acc;
    logic [ADDR_W-1:0] next_addr;

    // Foreign-ID beats are dropped entirely, including their rlast.
    always_comb begin
        beat_acc  = (state_q == StData) && rvalid && rready && (rid == RD_ID);
        next_addr = cur_addr + STRIDE_V;
    end

    // Job sequencing with registered handshake and address-channel outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cur_addr   <= '0;
            vec_left   <= '0;
            burst_cnt  <= '0;
            burst_beat <= '0;
            vec_beat   <= '0;
            req_ready  <= 1'b0;
            arvalid    <= 1'b0;
            araddr     <= '0;
            arlen      <= '0;
            arid       <= '0;
            rready     <= 1'b0;
            out_valid  <= 1'b0;
            err        <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid && req_ready) begin
                        req_ready  <= 1'b0;
                        cur_addr   <= req_addr;
                        vec_left   <= (req_num == 16'd0) ? 16'd1 : req_num;
                        burst_cnt  <= '0;
                        burst_beat <= '0;
                        vec_beat   <= '0;
                        arvalid    <= 1'b1;
                        araddr     <= req_addr;
                        arlen      <= ARLEN_V;
                        arid       <= RD_ID;
                        state_q    <= StAddr;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                StAddr: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state_q <= StData;
                    end
                end
                StData: begin
                    if (beat_acc) begin
                        if (vec_beat != BEATS_V) begin
                            vec_beat <= vec_beat + VB_W'(1);
                        end
                        if (burst_beat != BURST_LEN_V) begin
                            burst_beat <= burst_beat + BB_W'(1);
                        end
                        // rlast must coincide exactly with the final beat of a burst.
                        if (rlast != (burst_beat == LAST_BEAT_V)) begin
                            err <= 1'b1;
                        end
                        if (rlast) begin
                            cur_addr   <= next_addr;
                            burst_beat <= '0;
                            rready     <= 1'b0;
                            if (burst_cnt == LAST_BURST_V) begin
                                out_valid <= 1'b1;
                                state_q   <= StOut;
                            end else begin
                                burst_cnt <= burst_cnt + BC_W'(1);
                                arvalid   <= 1'b1;
                                araddr    <= next_addr;
                                state_q   <= StAddr;
                            end
                        end
                    end
                end
                StOut: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (vec_left == 16'd1) begin
                            req_ready <= 1'b1;
                            state_q   <= StIdle;
                        end else begin
                            vec_left   <= vec_left - 16'd1;
                            burst_cnt  <= '0;
                            burst_beat <= '0;
                            vec_beat   <= '0;
                            arvalid    <= 1'b1;
                            araddr     <= cur_addr;
                            state_q    <= StAddr;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    conv_rd_pack #(
        .DATA_W (DATA_W),
        .BEATS  (BEATS),
        .IDX_W  (IDX_W)
    ) u_pack (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (beat_acc && (vec_beat < BEATS_V)),
        .wr_idx  (vec_beat[IDX_W-1:0]),
        .wr_data (rdata),
        .data    (out_data)
    );

endmodule

// File: tb/tb_conv_rd_burst_bridge.sv
// Bench for conv_rd_burst_bridge: random slave and consumer, vector model
// built from the beats the slave actually delivered with the bridge's ID.
module tb_conv_rd_burst_bridge;

    localparam int BEATS  = 64;
    localparam int BURSTS = 4;
    localparam int BLEN   = 16;
    localparam int STRIDE = 64;
    localparam int VW     = 2048;

    logic            clk;
    logic            rst_n;
    logic            req_valid;
    logic            req_ready;
    logic [27:0]     req_addr;
    logic [15:0]     req_num;
    logic            out_valid;
    logic            out_ready;
    logic [VW-1:0]   out_data;
    logic            arvalid;
    logic            arready;
    logic [27:0]     araddr;
    logic [7:0]      arlen;
    logic [3:0]      arid;
    logic            rvalid;
    logic            rready;
    logic [31:0]     rdata;
    logic [3:0]      rid;
    logic            rlast;
    logic            err;

    conv_rd_burst_bridge dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_num   (req_num),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .arvalid   (arvalid),
        .arready   (arready),
        .araddr    (araddr),
        .arlen     (arlen),
        .arid      (arid),
        .rvalid    (rvalid),
        .rready    (rready),
        .rdata     (rdata),
        .rid       (rid),
        .rlast     (rlast),
        .err       (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    // Slave / consumer knobs, set by the test tasks.
    int ar_pct = 100;
    int r_wait_pct = 0;
    int foreign_pct = 0;
    int out_pct = 100;
    bit out_hold = 1'b0;
    bit data_idx_mode = 1'b0;
    int early_burst = -1;

    // Written only by the monitor.
    logic [27:0]   ar_log[$];
    int            ar_cnt = 0;
    int            ar_bad_attr = 0;
    int            ar_in_out = 0;
    logic [VW-1:0] got_vecs[$];

    // Written only by the read-data driver (the reference model lives here).
    int            bursts_started = 0;
    int            burst_no = 0;
    int            k = 0;
    int            burst_in_vec = 0;
    int            lat_bad = 0;
    logic [VW-1:0] exp_cur = '0;
    logic [VW-1:0] exp_vecs[$];

    // Address-channel ready with random stalls.
    initial begin
        arready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            arready = ($urandom_range(0, 99) < ar_pct);
        end
    end

    // Output consumer with optional hold.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            out_ready = out_hold ? 1'b0 : ($urandom_range(0, 99) < out_pct);
        end
    end

    // Monitor: values at negedge equal those seen by the next rising edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (arvalid && arready) begin
                ar_log.push_back(araddr);
                ar_cnt = ar_cnt + 1;
                if (arlen !== 8'd15 || arid !== 4'h1) ar_bad_attr = ar_bad_attr + 1;
            end
            if (out_valid && arvalid) ar_in_out = ar_in_out + 1;
            if (out_valid && out_ready) got_vecs.push_back(out_data);
        end
    end

    task automatic send_beat(input logic [3:0] id, input logic [31:0] d, input logic last,
                             output bit ab);
        int guard;
        guard = 0;
        ab = 1'b0;
        rvalid = 1'b1;
        rid = id;
        rdata = d;
        rlast = last;
        @(negedge clk);
        while (!(rready && rst_n)) begin
            if (!rst_n || guard > 2000) begin
                ab = 1'b1;
                break;
            end
            guard++;
            @(negedge clk);
        end
        if (!ab) begin
            @(posedge clk);
            #1;
        end
        rvalid = 1'b0;
        rid = 4'h0;
        rlast = 1'b0;
    endtask

    // Read-data driver: one burst per accepted AR, model updated per delivered beat.
    initial begin
        int          len;
        bit          ab;
        logic [31:0] d;
        rvalid = 1'b0;
        rid = 4'h0;
        rdata = 32'h0;
        rlast = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                bursts_started = ar_cnt;
                k = 0;
                burst_in_vec = 0;
                exp_cur = '0;
                continue;
            end
            if (ar_cnt == bursts_started) continue;
            bursts_started++;
            len = (burst_no == early_burst) ? 10 : BLEN;
            burst_no++;
            ab = 1'b0;
            for (int b = 0; b < len && !ab; b++) begin
                if ($urandom_range(0, 99) < foreign_pct) begin
                    send_beat(4'h2, $urandom, 1'($urandom_range(0, 1)), ab);
                end
                if (ab) break;
                if ($urandom_range(0, 99) < r_wait_pct) begin
                    @(posedge clk);
                    #1;
                end
                d = data_idx_mode ? 32'(k) : $urandom;
                send_beat(4'h1, d, (b == len - 1), ab);
                if (ab) break;
                if (k < BEATS) exp_cur[k*32 +: 32] = d;
                k++;
                if (b == len - 1) begin
                    burst_in_vec++;
                    if (burst_in_vec == BURSTS) begin
                        exp_vecs.push_back(exp_cur);
                        burst_in_vec = 0;
                        k = 0;
                        if (out_valid !== 1'b1) lat_bad++;
                    end
                end
            end
        end
    end

    task automatic issue_req(input logic [27:0] addr, input logic [15:0] num);
        int guard;
        guard = 0;
        req_valid = 1'b1;
        req_addr = addr;
        req_num = num;
        @(negedge clk);
        while (!req_ready && guard < 200) begin
            guard++;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic run_job(input string name, input logic [27:0] addr, input logic [15:0] num);
        int ar0, g0, e0, nv, guard, bad;
        logic [27:0] ea;
        ar0 = ar_log.size();
        g0 = got_vecs.size();
        e0 = exp_vecs.size();
        nv = (num == 16'd0) ? 1 : int'(num);
        issue_req(addr, num);
        guard = 0;
        while (got_vecs.size() < g0 + nv && guard < 20000) begin
            @(posedge clk);
            guard++;
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (got_vecs.size() != g0 + nv) begin
            errors++;
            $display("FAIL %s vec_count got %0d want %0d", name, got_vecs.size() - g0, nv);
        end
        checks++;
        if (ar_log.size() - ar0 != nv * BURSTS) begin
            errors++;
            $display("FAIL %s ar_count got %0d want %0d", name, ar_log.size() - ar0, nv * BURSTS);
        end
        bad = 0;
        for (int i = 0; i < nv * BURSTS && ar0 + i < ar_log.size(); i++) begin
            ea = addr + 28'(i * STRIDE);
            if (ar_log[ar0+i] !== ea && bad == 0) begin
                bad = 1;
                $display("FAIL %s ar_addr[%0d] got %h want %h", name, i, ar_log[ar0+i], ea);
            end
        end
        checks++;
        if (bad != 0) errors++;
        for (int v = 0; v < nv; v++) begin
            checks++;
            if (g0 + v >= got_vecs.size() || e0 + v >= exp_vecs.size()) begin
                errors++;
                $display("FAIL %s vec%0d missing got %0d want %0d", name, v,
                         got_vecs.size(), exp_vecs.size());
            end else if (got_vecs[g0+v] !== exp_vecs[e0+v]) begin
                errors++;
                $display("FAIL %s vec%0d data got %h want %h", name, v,
                         got_vecs[g0+v][255:0], exp_vecs[e0+v][255:0]);
            end
        end
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if ({req_ready, arvalid, rready, out_valid, err} !== 5'b0 || araddr !== 28'h0 ||
            arlen !== 8'h0 || arid !== 4'h0 || out_data !== '0) begin
            errors++;
            $display("FAIL %s got rdy=%b arv=%b rrdy=%b ov=%b err=%b addr=%h len=%h id=%h want all 0",
                     name, req_ready, arvalid, rready, out_valid, err, araddr, arlen, arid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 1'b0;
        req_addr = '0;
        req_num = '0;
        #1;
        check_idle_outputs("reset_state");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (req_ready !== 1'b1 || arvalid !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle got rdy=%b arv=%b ov=%b want 1 0 0",
                     req_ready, arvalid, out_valid);
        end
    endtask

    task automatic test_basic();
        int g0, bad;
        logic [VW-1:0] v;
        data_idx_mode = 1'b1;
        g0 = got_vecs.size();
        run_job("basic", 28'h100, 16'd1);
        bad = 0;
        if (g0 < got_vecs.size()) begin
            v = got_vecs[g0];
            for (int i = 0; i < BEATS; i++) if (v[i*32 +: 32] !== 32'(i)) bad++;
        end else begin
            bad = 1;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL basic_beat_index got %0d bad words want 0", bad);
        end
        checks++;
        if (ar_bad_attr != 0) begin
            errors++;
            $display("FAIL basic_arlen_arid got %0d bad ARs want 0", ar_bad_attr);
        end
        checks++;
        if (err !== 1'b0 || lat_bad != 0) begin
            errors++;
            $display("FAIL basic_err_latency got err=%b lat_bad=%0d want 0 0", err, lat_bad);
        end
        data_idx_mode = 1'b0;
    endtask

    task automatic stall_watch(output int bad);
        int guard;
        bad = 0;
        guard = 0;
        @(negedge clk);
        while (!out_valid && guard < 3000) begin
            guard++;
            @(negedge clk);
        end
        if (!out_valid) bad = 100;
        repeat (20) begin
            if (arvalid !== 1'b0 || out_valid !== 1'b1) bad++;
            @(negedge clk);
        end
        out_hold = 1'b0;
    endtask

    task automatic test_back_pressure();
        int ar0, bad, io0;
        ar0 = ar_log.size();
        io0 = ar_in_out;
        out_hold = 1'b1;
        fork
            run_job("back_pressure", 28'h100, 16'd2);
            stall_watch(bad);
        join
        checks++;
        if (bad != 0 || ar_in_out != io0) begin
            errors++;
            $display("FAIL stall_no_ar got bad=%0d ar_in_out=%0d want 0 0", bad, ar_in_out - io0);
        end
        checks++;
        if (ar_log.size() < ar0 + 5 || ar_log[ar0+4] !== 28'h200) begin
            errors++;
            $display("FAIL second_vec_addr got %h want 200",
                     (ar_log.size() > ar0 + 4) ? ar_log[ar0+4] : 28'hx);
        end
    endtask

    task automatic test_foreign_id();
        logic [27:0] a;
        foreign_pct = 40;
        r_wait_pct = 30;
        ar_pct = 60;
        out_pct = 70;
        for (int i = 0; i < 3; i++) begin
            a = 28'($urandom) & 28'hFFFFFFC;
            run_job("foreign", a, 16'($urandom_range(1, 3)));
        end
        run_job("num_zero", 28'h3000, 16'd0);
        checks++;
        if (err !== 1'b0 || lat_bad != 0 || ar_bad_attr != 0) begin
            errors++;
            $display("FAIL foreign_flags got err=%b lat_bad=%0d bad_ar=%0d want 0 0 0",
                     err, lat_bad, ar_bad_attr);
        end
        foreign_pct = 0;
        r_wait_pct = 0;
        ar_pct = 100;
        out_pct = 100;
    endtask

    task automatic test_wrap();
        int ar0;
        ar0 = ar_log.size();
        run_job("wrap", 28'hFFFFFC0, 16'd1);
        checks++;
        if (ar_log.size() < ar0 + 2 || ar_log[ar0+1] !== 28'h0000000) begin
            errors++;
            $display("FAIL wrap_addr got %h want 0000000",
                     (ar_log.size() > ar0 + 1) ? ar_log[ar0+1] : 28'hx);
        end
    endtask

    task automatic test_early_rlast();
        int ar0;
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_before_early got %b want 0", err);
        end
        ar0 = ar_log.size();
        early_burst = burst_no;
        run_job("early_rlast", 28'h400, 16'd1);
        early_burst = -1;
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_set got %b want 1", err);
        end
        checks++;
        if (ar_log.size() < ar0 + 2 || ar_log[ar0+1] !== 28'h440) begin
            errors++;
            $display("FAIL early_next_ar got %h want 440",
                     (ar_log.size() > ar0 + 1) ? ar_log[ar0+1] : 28'hx);
        end
        r_wait_pct = 20;
        run_job("after_early", 28'h800, 16'd1);
        r_wait_pct = 0;
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky got %b want 1", err);
        end
    endtask

    task automatic test_reset_mid_burst();
        int b0, guard;
        b0 = burst_no;
        r_wait_pct = 10;
        issue_req(28'h1000, 16'd1);
        guard = 0;
        while (burst_no < b0 + 3 && guard < 3000) begin
            guard++;
            @(posedge clk);
        end
        checks++;
        if (burst_no < b0 + 3) begin
            errors++;
            $display("FAIL reach_burst2 got %0d bursts want %0d", burst_no - b0, 3);
        end
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("mid_burst_reset");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        r_wait_pct = 0;
        run_job("after_reset", 28'h2000, 16'd1);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_after_reset got %b want 0", err);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_pressure();
        test_foreign_id();
        test_wrap();
        test_early_rlast();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_rd_burst_bridge.md
CONV_RD_BURST_BRIDGE -- requirements
Module: conv_rd_burst_bridge

Interface
REQ-001 SHALL have parameter CH_NUM, default 64, meaning channels per output vector.
REQ-002 SHALL have parameter PIX_W, default 32, meaning bits per channel pixel.
REQ-003 SHALL have parameter DATA_W, default 32, meaning read-data bus width.
REQ-004 SHALL have parameter BURST_LEN, default 16, meaning beats per read burst.
REQ-005 SHALL have parameter ADDR_W, default 28, meaning byte-address width.
REQ-006 SHALL have parameter RD_ID, default 4'h1, meaning transaction ID owned by this bridge.
REQ-007 SHALL have port clk, input, 1, meaning clock.
REQ-008 SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-009 SHALL have port req_valid/req_ready, input/output, 1/1, meaning job request handshake.
REQ-010 SHALL have port req_addr, input, ADDR_W, meaning job start byte address.
REQ-011 SHALL have port req_num, input, 16, meaning vectors in the job (0 treated as 1).
REQ-012 SHALL have port out_valid/out_ready, output/input, 1/1, meaning vector handshake.
REQ-013 SHALL have port out_data, output, CH_NUM*PIX_W, meaning assembled channel vector.
REQ-014 SHALL have ports arvalid (out, 1), arready (in, 1), araddr (out, ADDR_W), arlen (out, 8), arid (out, 4), meaning read-address channel.
REQ-015 SHALL have ports rvalid (in, 1), rready (out, 1), rdata (in, DATA_W), rid (in, 4), rlast (in, 1), meaning read-data channel.
REQ-016 SHALL have port err, output, 1, meaning sticky burst-length protocol error.

Function
REQ-017 SHALL derive BEATS=CH_NUM*PIX_W/DATA_W, BURSTS=BEATS/BURST_LEN, STRIDE=BURST_LEN*DATA_W/8 bytes; non-integer results SHALL be an elaboration error.
REQ-018 SHALL implement states IDLE, ADDR, DATA, OUT.
REQ-019 IDLE: req_ready=1; on req_valid latch cur_addr=req_addr and vec_left=max(req_num,1), clear beat/burst counters, go ADDR.
REQ-020 ADDR: arvalid=1, araddr=cur_addr, arlen=BURST_LEN-1, arid=RD_ID held stable until arready; on arready go DATA.
REQ-021 DATA: rready=1; beat accepted when rvalid && rid==RD_ID; beats with other rid SHALL be ignored (not stored, not counted, rlast ignored).
REQ-022 Accepted beat k (0..BEATS-1 within vector) SHALL be written to out_data[k*DATA_W +: DATA_W].
REQ-023 On accepted rlast: cur_addr+=STRIDE (wrap modulo 2^ADDR_W); if burst_cnt==BURSTS-1 go OUT, else burst_cnt++ and go ADDR.
REQ-024 If accepted rlast arrives on a beat other than the BURST_LEN-th, or BURST_LEN beats pass without rlast, err SHALL set; burst end SHALL still follow rlast.
REQ-025 OUT: out_valid=1, out_data stable; on out_ready: vec_left==1 go IDLE, else vec_left--, clear counters, go ADDR.
REQ-026 Outputs arvalid, rready, out_valid, req_ready SHALL be 0 outside their named states.
REQ-027 No new vector data SHALL be written while out_valid=1 (single output buffer; backpressure stalls AR issue).
REQ-028 Latency from last accepted beat to out_valid SHALL be 1 cycle.

Reset
REQ-029 rst_n low SHALL asynchronously force IDLE, counters 0, err 0, out_data 0, all handshake outputs 0, araddr/arlen/arid 0; mid-burst reset SHALL abandon the job.

Structure
REQ-030 SHALL place state enum, RD_ID default, and arlen width in shared package conv_bus_pkg.
REQ-031 SHALL implement beat-indexed packing in one sub-module conv_rd_pack.

Verification
REQ-032 Defaults, req_addr=0x100, req_num=1, zero-wait slave -> 4 ARs at 0x100,0x140,0x180,0x1C0 each arlen=15; out_data beat k = k; one out_valid.
REQ-033 req_num=2, out_ready low 20 cycles on first vector -> no AR during stall; second vector starts at 0x200.
REQ-034 Interleave beats with rid=2 between rid=1 beats -> rid=2 data absent from out_data; count unaffected.
REQ-035 rlast on 10th beat of burst 0 -> err=1, next AR at +0x40, err stays 1 until reset.
REQ-036 rst_n low during burst 2 -> all outputs 0 next edge; new request afterwards completes normally.
REQ-037 req_addr=0xFFFFFC0 -> second AR araddr=0x0000000.
